tone_generator: RTL



---
 rtl/audio_pkg.sv | 53 +++++
 rtl/tone_generator_if.sv | 26 ++
 rtl/audio_sample_tick.sv | 35 +++
 rtl/tone_generator.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared constants for the tone generator: chromatic note table
//                (C4..D#5), tone half-period helper, tone FSM state encoding
//                and default amplitude settings.
//                Optional macro: TONE_GENERATOR_ENVELOPE_EN selects the
//                four-state envelope FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int TONE_CNT_W = 17;

    localparam logic signed [15:0] DEFAULT_AMPLITUDE = 16'sh2000;
    localparam logic signed [15:0] DEFAULT_RAMP_STEP = 16'sh0100;

    // Note frequencies in centi-Hz, index 0 = C4 ... 9 = A4 ... 15 = D#5
    localparam int unsigned NOTE_HZ_X100 [16] = '{
        32'd26163, 32'd27718, 32'd29366, 32'd31113,
        32'd32963, 32'd34923, 32'd36999, 32'd39200,
        32'd41530, 32'd44000, 32'd46616, 32'd49388,
        32'd52325, 32'd55437, 32'd58733, 32'd62225
    };

    // round(clk_hz / (2 * note_hz)) in integer arithmetic on centi-Hz values
    function automatic logic [TONE_CNT_W-1:0] half_period(
        input logic [3:0]      idx,
        input longint unsigned clk_hz
    );
        longint unsigned hz;
        longint unsigned cycles;
        hz     = 64'(NOTE_HZ_X100[idx]);
        cycles = (clk_hz * 64'd100 + hz) / (64'd2 * hz);
        return TONE_CNT_W'(cycles);
    endfunction

`ifdef TONE_GENERATOR_ENVELOPE_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } tone_state_t;
`else
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } tone_state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/tone_generator_if.sv
`default_nettype none
// ============================================================================
//  Module      : tone_generator_if
//  Description : Tone request / audio output bundle between the audio
//                controller (master) and the tone generator (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface tone_generator_if;
    logic               EnableSound;
    logic [3:0]         frequency;
    logic               sample_tick;
    logic signed [15:0] audio_sample;
    logic               square_out;
    logic               busy;

    modport master (
        output EnableSound, frequency,
        input  sample_tick, audio_sample, square_out, busy
    );

    modport slave (
        input  EnableSound, frequency,
        output sample_tick, audio_sample, square_out, busy
    );
endinterface
`default_nettype wire

// File: rtl/audio_sample_tick.sv
`default_nettype none
// ============================================================================
//  Module      : audio_sample_tick
//  Description : Free-running sample-rate divider. Emits a one-cycle strobe
//                every CLK_FREQ_HZ / SAMPLE_RATE_HZ clocks (truncated).
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_sample_tick #(
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int SAMPLE_RATE_HZ = 48_000
) (
    input  logic clk,
    input  logic reset,
    output logic sample_tick
);
    localparam int                 c_sample_div = CLK_FREQ_HZ / SAMPLE_RATE_HZ;
    localparam int                 c_cnt_w      = (c_sample_div > 1) ? $clog2(c_sample_div) : 1;
    localparam logic [c_cnt_w-1:0] c_last       = c_cnt_w'(c_sample_div - 1);

    logic [c_cnt_w-1:0] r_count;

    // Count 0..SAMPLE_DIV-1 and wrap, independent of any tone activity
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign sample_tick = (r_count == c_last);
endmodule
`default_nettype wire

// File: rtl/tone_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tone_generator
//  Description : Maps a 4-bit chromatic note index to a square-wave tone and
//                emits a registered signed 16-bit PCM sample once per sample
//                tick, plus a raw 1-bit square output.
//                Optional macro: TONE_GENERATOR_ENVELOPE_EN adds a linear
//                attack/release envelope (IDLE/ATTACK/SUSTAIN/RELEASE).
//  Revision    : 1.0 - initial release
// ============================================================================
module tone_generator
    import audio_pkg::*;
#(
    parameter int                 CLK_FREQ_HZ    = 50_000_000,
    parameter int                 SAMPLE_RATE_HZ = 48_000,
    parameter logic signed [15:0] AMPLITUDE      = DEFAULT_AMPLITUDE,
    parameter logic signed [15:0] RAMP_STEP      = DEFAULT_RAMP_STEP
) (
    input  logic           clk,
    input  logic           reset,
    tone_generator_if.slave bus
);
    // Envelope arithmetic shares the step's width
    localparam int c_amp_w = $bits(RAMP_STEP);

    tone_state_t               r_state;
    tone_state_t               w_next_state;
    logic [TONE_CNT_W-1:0]     r_count;
    logic [3:0]                r_freq;
    logic                      r_phase;
    logic signed [15:0]        r_sample;
    logic signed [c_amp_w-1:0] w_amp_level;
    logic                      w_tick;
    logic                      w_active;
    logic                      w_wrap;
    logic [TONE_CNT_W-1:0]     w_half_tbl [16];

    audio_sample_tick #(
        .CLK_FREQ_HZ    (CLK_FREQ_HZ),
        .SAMPLE_RATE_HZ (SAMPLE_RATE_HZ)
    ) u_sample_tick (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (w_tick)
    );

    // Half-period table folds to constants at elaboration time
    for (genvar i = 0; i < 16; i++) begin : g_half_tbl
        assign w_half_tbl[i] = half_period(4'(i), 64'(CLK_FREQ_HZ));
    end

    assign w_active = (r_state != ST_IDLE);
    assign w_wrap   = (r_count == w_half_tbl[r_freq] - 1'b1);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

`ifdef TONE_GENERATOR_ENVELOPE_EN
    logic signed [c_amp_w-1:0] r_amp;
    logic signed [c_amp_w-1:0] w_amp_next;

    // Envelope FSM next-state: ramp up while requested, ramp down otherwise
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (bus.EnableSound)  w_next_state = ST_ATTACK;
            ST_ATTACK:  if (!bus.EnableSound) w_next_state = ST_RELEASE;
                        else if (r_amp >= AMPLITUDE) w_next_state = ST_SUSTAIN;
            ST_SUSTAIN: if (!bus.EnableSound) w_next_state = ST_RELEASE;
            ST_RELEASE: if (bus.EnableSound)  w_next_state = ST_ATTACK;
                        else if (r_amp == '0) w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Envelope step per sample tick, saturating at AMPLITUDE and floored at 0
    always_comb begin
        w_amp_next = r_amp;
        if (w_tick && r_state == ST_ATTACK) begin
            w_amp_next = (r_amp > AMPLITUDE - RAMP_STEP) ? AMPLITUDE : r_amp + RAMP_STEP;
        end else if (w_tick && r_state == ST_RELEASE) begin
            w_amp_next = (r_amp < RAMP_STEP) ? '0 : r_amp - RAMP_STEP;
        end
    end

    // Envelope amplitude register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_amp <= '0;
        end else begin
            r_amp <= w_amp_next;
        end
    end

    // The sample taken on a tick reflects the envelope step of that same tick
    assign w_amp_level = w_amp_next;
`else
    // Hard-gated FSM next-state: play exactly while requested
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (bus.EnableSound)  w_next_state = ST_PLAY;
            ST_PLAY: if (!bus.EnableSound) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_amp_level = AMPLITUDE;
`endif

    // Tone counter and phase; note index is only reloaded at phase edges so a
    // mid-tone frequency change never produces a short half-period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_phase <= 1'b0;
            r_freq  <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_next_state != ST_IDLE) begin
                r_freq  <= bus.frequency;
                r_count <= '0;
                r_phase <= 1'b1;
            end
        end else if (w_next_state == ST_IDLE) begin
            r_count <= '0;
            r_phase <= 1'b0;
        end else if (w_wrap) begin
            r_count <= '0;
            r_phase <= ~r_phase;
            r_freq  <= bus.frequency;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // PCM sample register, updated only on sample ticks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample <= '0;
        end else if (w_tick) begin
            if (!w_active) begin
                r_sample <= '0;
            end else begin
                r_sample <= r_phase ? 16'(w_amp_level) : 16'(-w_amp_level);
            end
        end
    end

    assign bus.sample_tick  = w_tick;
    assign bus.audio_sample = r_sample;
    assign bus.square_out   = w_active & r_phase;
    assign bus.busy         = w_active;
endmodule
`default_nettype wire
